// File: rtl/ram.sv
// Single-port synchronous RAM: en=1 writes d_in to mem[addr], en=0 registers mem[addr] onto d_out.
// Asynchronous active-high reset clears the whole array and the read register.
module ram #(
    parameter int unsigned ADD_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADD_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out
);

    localparam int unsigned DEPTH = 2 ** ADD_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array; reset clears every word so unwritten reads return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[addr] <= d_in;
        end
    end

    // Read register holds across write cycles (no write-through)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= '0;
        end else if (!en) begin
            d_out <= mem[addr];
        end
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: stimulus pushes expected d_out per issued edge, a monitor pops and compares.
module tb_ram;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;
    logic [DW-1:0] exp_q [$];

    ram #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .addr  (addr),
        .d_in  (d_in),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: d_out=0x%02h expected=0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain array plus the last value read out
    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_dout = '0;
    endtask

    // Drive one operation for the coming rising edge and queue the d_out expected after it
    task automatic apply(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        en   = we;
        addr = a;
        d_in = d;
        if (we) ref_mem[a] = d;
        else    ref_dout   = ref_mem[a];
        exp_q.push_back(ref_dout);
    endtask

    task automatic op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        apply(we, a, d);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op(1'b1, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        op(1'b0, a, '0);
    endtask

    // Reset asserted between edges; d_out must clear without waiting for a clock
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check("async_reset_clear", d_out, 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold", d_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, '0, '0);
    endtask

    // Monitor: one expected value per issued edge
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            check("scoreboard", d_out, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        addr = '0;
        d_in = '0;
        model_clear();
        #2;
        check("reset_initial", d_out, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 4'd0, '0);

        // Reset then read
        rd(4'd5);
        rd(4'd15);

        // Write then read back
        wr(4'd0, 8'h3A);
        wr(4'd1, 8'h5A);
        wr(4'd2, 8'h7A);
        rd(4'd0);
        rd(4'd1);
        rd(4'd2);

        // Hold during write
        rd(4'd0);
        wr(4'd3, 8'hFF);
        wr(4'd4, 8'h44);

        // Overwrite at top address, then bottom address
        wr(4'd15, 8'h11);
        wr(4'd15, 8'h22);
        rd(4'd15);
        wr(4'd0, 8'hA5);
        rd(4'd0);
        rd(4'd3);

        // Asynchronous reset mid-run, then contents must be gone
        mid_reset();
        rd(4'd1);
        rd(4'd2);
        rd(4'd15);

        // Read-after-write on the next edge
        wr(4'd7, 8'h5C);
        rd(4'd7);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                op(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom()));
            end
        end

        // Sweep every address
        for (int i = 0; i < int'(DEPTH); i++) rd(AW'(i));

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
